// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared register-file widths, index/request types and the
//               round-robin pointer helper for the writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Next round-robin position after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first request
//               found searching upward from ptr (mod N) and computes the
//               pointer value to register for the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic [PW-1:0] ptr_nxt
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    // The pointer moves just past the winner only when a transfer happens.
    always_comb begin
        ptr_nxt = ptr;
        if (advance) begin
            ptr_nxt = PW'(rr_next(int'(gnt_idx), N));
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the single register-file write port among N_REQ
//               writeback sources with round-robin arbitration, registers the
//               winning write, and keeps a pending-write scoreboard that
//               reports RAW hazards and stalls WAW issues.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int N_REQ       = 3,
    parameter int XLEN        = regfile_pkg::XLEN,
    parameter int NREG        = regfile_pkg::NREG,
    localparam int REG_AW     = $clog2(NREG),
    localparam int PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*REG_AW-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]   req_data,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_rd,
    output logic                    issue_stall,
    input  logic [REG_AW-1:0]       rs1,
    input  logic [REG_AW-1:0]       rs2,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic                    RegWrite,
    output logic [REG_AW-1:0]       writeReg,
    output logic [XLEN-1:0]         writeData
);

    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_gnt_idx;
    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_xfer;
    logic              w_wr_en;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_data;
    logic [NREG-1:0]   r_pending;
    logic [NREG-1:0]   w_pending_nxt;
    logic              w_issue_set;
    logic              w_busy_issue;
    logic              w_busy_rs1;
    logic              w_busy_rs2;

    // Requests are masked during reset so nothing is granted or consumed.
    assign w_req = RST ? '0 : req_valid;

    rr_arbiter #(
        .N       (N_REQ),
        .PW      (PW)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .advance (w_xfer),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .ptr_nxt (w_ptr_nxt)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |w_gnt;

    // Select destination and data of the granted slot.
    always_comb begin
        w_rd   = '0;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_rd   = req_rd[i*REG_AW +: REG_AW];
                w_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    assign w_wr_en = w_xfer && (w_rd != '0);

    // A register is busy if it is pending or its write lands this cycle.
    assign w_busy_issue = r_pending[issue_rd] || (RegWrite && (writeReg == issue_rd));
    assign w_busy_rs1   = r_pending[rs1]      || (RegWrite && (writeReg == rs1));
    assign w_busy_rs2   = r_pending[rs2]      || (RegWrite && (writeReg == rs2));

    assign issue_stall = issue_valid && (issue_rd != '0) && w_busy_issue;
    assign hazard1     = (rs1 != '0) && w_busy_rs1;
    assign hazard2     = (rs2 != '0) && w_busy_rs2;

    assign w_issue_set = issue_valid && !issue_stall && (issue_rd != '0);

    // Scoreboard next state: clear first so a same-index set still wins; x0 never pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_en) begin
            w_pending_nxt[w_rd] = 1'b0;
        end
        if (w_issue_set) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard and round-robin pointer state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
            r_ptr     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    // Register-file write port, one cycle behind the transfer; idle cycles drive zeros.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            RegWrite  <= w_wr_en;
            writeReg  <= w_wr_en ? w_rd   : '0;
            writeData <= w_wr_en ? w_data : '0;
        end
    end

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Directed self-checking bench for regfile_wb_scheduler.
//               Inputs change 1 ns after the rising edge, outputs are
//               sampled 1 ns after that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    localparam int N_REQ  = 3;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*REG_AW-1:0] req_rd;
    logic [N_REQ*XLEN-1:0]   req_data;
    logic                    issue_valid;
    logic [REG_AW-1:0]       issue_rd;
    logic                    issue_stall;
    logic [REG_AW-1:0]       rs1;
    logic [REG_AW-1:0]       rs2;
    logic                    hazard1;
    logic                    hazard2;
    logic                    RegWrite;
    logic [REG_AW-1:0]       writeReg;
    logic [XLEN-1:0]         writeData;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_scheduler #(
        .N_REQ       (N_REQ),
        .XLEN        (XLEN),
        .NREG        (NREG)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .RegWrite    (RegWrite),
        .writeReg    (writeReg),
        .writeData   (writeData)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = 3'b111; issue_valid = 1'b0; issue_rd = '0;
        rs1 = 5'd5; rs2 = 5'd6; req_rd = '0; req_data = '0;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
            n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
            n_cmp++; if ({hazard1, hazard2} !== 2'b00) begin n_bad++; $display("FAIL reset_hazard: got %b want 00", {hazard1, hazard2}); end
        end
        RST = 1'b0; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL release_grant: got %b want 001", req_ready); end
        req_valid = 3'b000;
    endtask

    task automatic test_single_write();
        req_valid = 3'b001; req_rd[0 +: 5] = 5'd5; req_data[0 +: 32] = 32'hDEADBEEF; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready: got %b want 001", req_ready); end
        step(); req_valid = 3'b000; #1;
        n_cmp++; if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", RegWrite); end
        n_cmp++; if (writeReg !== 5'd5) begin n_bad++; $display("FAIL single_reg: got %0d want 5", writeReg); end
        n_cmp++; if (writeData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h want deadbeef", writeData); end
        step(); #1;
        n_cmp++; if ({RegWrite, writeReg, writeData} !== 38'd0) begin n_bad++; $display("FAIL single_idle: got we=%b reg=%0d data=%h want all 0", RegWrite, writeReg, writeData); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [4:0]  exp_r  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        logic [31:0] exp_d  [6] = '{32'hA0, 32'hB1, 32'hC2, 32'hA0, 32'hB1, 32'hC2};
        do_reset();
        req_rd   = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC2, 32'hB1, 32'hA0};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (req_ready !== exp_g[k]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g[k]); end
            if (k > 0) begin
                n_cmp++; if ({RegWrite, writeReg, writeData} !== {1'b1, exp_r[k-1], exp_d[k-1]})
                    begin n_bad++; $display("FAIL rr_write[%0d]: got we=%b reg=%0d data=%h want we=1 reg=%0d data=%h", k, RegWrite, writeReg, writeData, exp_r[k-1], exp_d[k-1]); end
            end
            step();
        end
        req_valid = 3'b000; #1;
        n_cmp++; if ({RegWrite, writeReg, writeData} !== {1'b1, 5'd3, 32'hC2}) begin n_bad++; $display("FAIL rr_last: got we=%b reg=%0d data=%h want we=1 reg=3 data=c2", RegWrite, writeReg, writeData); end
        step();
    endtask

    task automatic test_raw_hazard();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0; #1;
        n_cmp++; if ({hazard1, issue_stall} !== 2'b00) begin n_bad++; $display("FAIL raw_t0: got haz1/stall=%b want 00", {hazard1, issue_stall}); end
        step(); issue_valid = 1'b0; #1;
        n_cmp++; if (hazard1 !== 1'b1) begin n_bad++; $display("FAIL raw_t1: got hazard1=%b want 1", hazard1); end
        step(); rs2 = 5'd7; #1;
        n_cmp++; if ({hazard1, hazard2} !== 2'b11) begin n_bad++; $display("FAIL raw_t2: got haz1/haz2=%b want 11", {hazard1, hazard2}); end
        step(); rs2 = 5'd0; req_valid = 3'b010; req_rd[5 +: 5] = 5'd7; req_data[32 +: 32] = 32'h7777; #1;
        n_cmp++; if ({req_ready, hazard1} !== {3'b010, 1'b1}) begin n_bad++; $display("FAIL raw_t3: got ready=%b haz1=%b want 010/1", req_ready, hazard1); end
        step(); req_valid = 3'b000; #1;
        n_cmp++; if ({RegWrite, writeReg, hazard1} !== {1'b1, 5'd7, 1'b1}) begin n_bad++; $display("FAIL raw_t4: got we=%b reg=%0d haz1=%b want 1/7/1", RegWrite, writeReg, hazard1); end
        step(); #1;
        n_cmp++; if (hazard1 !== 1'b0) begin n_bad++; $display("FAIL raw_t5: got hazard1=%b want 0", hazard1); end
    endtask

    task automatic test_waw_stall();
        issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd0; #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL waw_t0: got stall=%b want 0", issue_stall); end
        step(); #1;
        n_cmp++; if ({issue_stall, hazard1} !== 2'b10) begin n_bad++; $display("FAIL waw_t1: got stall/haz1(rs1=0)=%b want 10", {issue_stall, hazard1}); end
        step(); req_valid = 3'b100; req_rd[10 +: 5] = 5'd9; req_data[64 +: 32] = 32'h9999; #1;
        n_cmp++; if ({req_ready, issue_stall} !== {3'b100, 1'b1}) begin n_bad++; $display("FAIL waw_t2: got ready=%b stall=%b want 100/1", req_ready, issue_stall); end
        step(); req_valid = 3'b000; #1;
        n_cmp++; if ({RegWrite, issue_stall} !== 2'b11) begin n_bad++; $display("FAIL waw_t3: got we/stall=%b want 11", {RegWrite, issue_stall}); end
        step(); #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL waw_t4: got stall=%b want 0", issue_stall); end
        issue_rd = 5'd0; #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL waw_rd0: got stall=%b want 0", issue_stall); end
        issue_valid = 1'b0;
        step();
    endtask

    task automatic test_rd0_and_reset();
        req_valid = 3'b100; req_rd[10 +: 5] = 5'd0; req_data[64 +: 32] = 32'h1; #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rd0_grant: got %b want 100", req_ready); end
        step(); req_valid = 3'b000; #1;
        n_cmp++; if ({RegWrite, writeReg, writeData} !== 38'd0) begin n_bad++; $display("FAIL rd0_nowrite: got we=%b reg=%0d data=%h want all 0", RegWrite, writeReg, writeData); end
        issue_valid = 1'b1; issue_rd = 5'd4; rs1 = 5'd4; #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL rst_issue4: got stall=%b want 0", issue_stall); end
        step(); issue_valid = 1'b0; req_valid = 3'b001; req_rd[0 +: 5] = 5'd6; req_data[0 +: 32] = 32'h66; rs2 = 5'd6; #1;
        n_cmp++; if ({req_ready, hazard1} !== {3'b001, 1'b1}) begin n_bad++; $display("FAIL rst_pre: got ready=%b haz1=%b want 001/1", req_ready, hazard1); end
        step(); req_valid = 3'b111; RST = 1'b1; #1;
        n_cmp++; if ({RegWrite, writeReg, hazard2, req_ready} !== {1'b1, 5'd6, 1'b1, 3'b000}) begin n_bad++; $display("FAIL rst_inflight: got we=%b reg=%0d haz2=%b ready=%b want 1/6/1/000", RegWrite, writeReg, hazard2, req_ready); end
        step(); RST = 1'b0; req_valid = 3'b000; issue_valid = 1'b1; issue_rd = 5'd4; #1;
        n_cmp++; if ({RegWrite, hazard1, hazard2, issue_stall} !== 4'b0000) begin n_bad++; $display("FAIL rst_after: got we/haz1/haz2/stall=%b want 0000", {RegWrite, hazard1, hazard2, issue_stall}); end
        issue_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_raw_hazard();
        test_waw_stall();
        test_rd0_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire
